regfile_wb_arbiter: RTL and testbench

- Writer-side front end for the 32x32 register file.
- Merges two writeback sources onto the register file's single write port:
  - ALU pipeline: fixed-latency, cannot be stalled.
  - LSU/multi-cycle unit: valid/ready handshake.
- Buffers LSU results in a small FIFO while the ALU holds the port.
- Drives registered we/rd/wd and a pending-destination mask for the hazard unit.

---
 rtl/regfile_wb_arbiter.sv | 136 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges the ALU writeback stream and the handshaked
// LSU writeback stream onto the register file's single write port.
// The ALU always wins the port. LSU results are queued in a small FIFO
// and are written in acceptance order. An ALU write to the same register
// marks older queued entries as dead.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_wd,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_wd,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wd,
    output logic [31:0]     pending_mask
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr, rptr;
    logic [AW:0]      count;
    logic [AW-1:0]    head, tail;
    logic             full, empty;
    logic             rdy_q;

    logic [4:0]       q_rd [DEPTH];
    logic [XLEN-1:0]  q_wd [DEPTH];
    // A live bit is set on push and cleared on pop or squash, so a set bit
    // also implies that the slot holds a valid entry.
    logic [DEPTH-1:0] q_live;

    logic             xfer, push, pop, squash, sel, sel_we;
    logic [4:0]       sel_rd;
    logic [XLEN-1:0]  sel_wd;

    assign count = wptr - rptr;
    assign head  = rptr[AW-1:0];
    assign tail  = wptr[AW-1:0];
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);

    // rdy_q keeps lsu_ready low until the first edge after reset release
    assign lsu_ready = rdy_q && !full;
    assign xfer      = lsu_valid && lsu_ready;

    // Per-cycle selection: ALU first, then FIFO head, then LSU bypass
    always_comb begin
        sel    = 1'b0;
        sel_we = 1'b0;
        sel_rd = '0;
        sel_wd = '0;
        pop    = 1'b0;
        push   = 1'b0;
        squash = 1'b0;
        if (alu_valid) begin
            sel    = 1'b1;
            sel_rd = alu_rd;
            sel_wd = alu_wd;
            sel_we = (alu_rd != 5'd0);
            squash = (alu_rd != 5'd0);
            push   = xfer;
        end else if (!empty) begin
            sel    = 1'b1;
            pop    = 1'b1;
            sel_rd = q_rd[head];
            sel_wd = q_wd[head];
            sel_we = q_live[head] && (q_rd[head] != 5'd0);
            push   = xfer;
        end else if (xfer) begin
            sel    = 1'b1;
            sel_rd = lsu_rd;
            sel_wd = lsu_wd;
            sel_we = (lsu_rd != 5'd0);
        end
    end

    // Ready enable, FIFO pointers and registered write-port outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            wptr  <= '0;
            rptr  <= '0;
            rf_we <= 1'b0;
            rf_rd <= '0;
            rf_wd <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            rf_we <= sel_we;
            if (sel) begin
                rf_rd <= sel_rd;
                rf_wd <= sel_wd;
            end
        end
    end

    // FIFO payload storage, no reset needed since live bits gate its use
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[tail] <= lsu_rd;
            q_wd[tail] <= lsu_wd;
        end
    end

    // Live bits: squash before push so a same-cycle LSU entry stays live
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_live <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (squash && q_live[i] && (q_rd[i] == alu_rd))
                    q_live[i] <= 1'b0;
            end
            if (pop)  q_live[head] <= 1'b0;
            if (push) q_live[tail] <= 1'b1;
        end
    end

    // Pending-destination mask over live queued entries, x0 excluded
    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (q_live[i]) pending_mask[q_rd[i]] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_wd;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic [31:0] pending_mask;

    int checks = 0;
    int passes = 0;

    regfile_wb_arbiter #(.XLEN(32), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_wd       (alu_wd),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_wd       (lsu_wd),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wd        (rf_wd),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("fifo_count_le_depth", 32'(dut.count <= 2), 32'd1);
    endtask

    task automatic wr(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] wd);
        chk({tag, "_we"}, 32'(rf_we), 32'(we));
        if (we) begin
            chk({tag, "_rd"}, 32'(rf_rd), 32'(rd));
            chk({tag, "_wd"}, rf_wd, wd);
        end
    endtask

    initial begin
        rst_n = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_wd = '0;
        #3;
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_mask", pending_mask, 32'd0);
        chk("rst_ready", 32'(lsu_ready), 32'd0);
        #9 rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 32'(lsu_ready), 32'd1);
        wr("idle", 1'b0, 5'd0, 32'd0);

        // ALU-only write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'h1234;
        tick();
        alu_valid = 1'b0;
        wr("alu", 1'b1, 5'd5, 32'h1234);
        tick();
        wr("alu_n2", 1'b0, 5'd0, 32'd0);

        // LSU bypass
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'hDEAD;
        tick();
        lsu_valid = 1'b0;
        wr("bypass", 1'b1, 5'd7, 32'hDEAD);
        chk("bypass_mask", pending_mask, 32'd0);

        // Contention and backpressure
        alu_valid = 1'b1; alu_rd = 5'd20; alu_wd = 32'h20;
        lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_wd = 32'h111;
        tick();
        wr("cont_alu20", 1'b1, 5'd20, 32'h20);
        chk("cont_mask1", pending_mask, 32'h2);
        chk("cont_ready1", 32'(lsu_ready), 32'd1);
        alu_rd = 5'd21; alu_wd = 32'h21; lsu_rd = 5'd2; lsu_wd = 32'h222;
        tick();
        wr("cont_alu21", 1'b1, 5'd21, 32'h21);
        chk("cont_mask_full", pending_mask, 32'h6);
        chk("cont_ready_full", 32'(lsu_ready), 32'd0);
        alu_rd = 5'd22; alu_wd = 32'h22; lsu_rd = 5'd3; lsu_wd = 32'h333;
        tick();
        wr("cont_alu22", 1'b1, 5'd22, 32'h22);
        chk("cont_ready_full2", 32'(lsu_ready), 32'd0);
        alu_rd = 5'd23; alu_wd = 32'h23;
        tick();
        wr("cont_alu23", 1'b1, 5'd23, 32'h23);
        chk("cont_ready_full3", 32'(lsu_ready), 32'd0);
        alu_valid = 1'b0;
        tick();
        wr("cont_pop1", 1'b1, 5'd1, 32'h111);
        chk("cont_ready_after_pop", 32'(lsu_ready), 32'd1);
        chk("cont_mask2", pending_mask, 32'h4);
        tick();
        lsu_valid = 1'b0;
        wr("cont_pop2", 1'b1, 5'd2, 32'h222);
        chk("cont_mask3", pending_mask, 32'h8);
        tick();
        wr("cont_pop3", 1'b1, 5'd3, 32'h333);
        chk("cont_mask_empty", pending_mask, 32'd0);
        tick();
        wr("cont_idle", 1'b0, 5'd0, 32'd0);

        // Squash, with a same-cycle LSU write to the same rd staying live
        alu_valid = 1'b1; alu_rd = 5'd4; alu_wd = 32'h44;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_wd = 32'h99;
        tick();
        wr("sq_alu4", 1'b1, 5'd4, 32'h44);
        chk("sq_mask_q", pending_mask, 32'h200);
        alu_rd = 5'd9; alu_wd = 32'hA5; lsu_rd = 5'd9; lsu_wd = 32'h77;
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        wr("sq_alu9", 1'b1, 5'd9, 32'hA5);
        chk("sq_mask_newlive", pending_mask, 32'h200);
        tick();
        wr("sq_dead_pop", 1'b0, 5'd0, 32'd0);
        chk("sq_mask_after_dead", pending_mask, 32'h200);
        tick();
        wr("sq_live_pop", 1'b1, 5'd9, 32'h77);
        chk("sq_mask_clear", pending_mask, 32'd0);

        // x0 handling
        alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'hBAD0;
        tick();
        alu_valid = 1'b0;
        wr("x0_alu", 1'b0, 5'd0, 32'd0);
        chk("x0_ready", 32'(lsu_ready), 32'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wd = 32'hBAD1;
        tick();
        wr("x0_lsu_bypass", 1'b0, 5'd0, 32'd0);
        chk("x0_mask1", pending_mask, 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h3;
        lsu_rd = 5'd0; lsu_wd = 32'hBAD2;
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        wr("x0_alu3", 1'b1, 5'd3, 32'h3);
        chk("x0_mask_queued", pending_mask, 32'd0);
        chk("x0_queued_count", 32'(dut.count), 32'd1);
        tick();
        wr("x0_pop", 1'b0, 5'd0, 32'd0);
        chk("x0_empty_count", 32'(dut.count), 32'd0);

        // Reset with a full FIFO
        alu_valid = 1'b1; alu_rd = 5'd30; alu_wd = 32'h30;
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_wd = 32'hB;
        tick();
        lsu_rd = 5'd12; lsu_wd = 32'hC; alu_rd = 5'd31;
        tick();
        chk("pre_rst_mask", pending_mask, 32'h1800);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_we", 32'(rf_we), 32'd0);
        chk("midrst_mask", pending_mask, 32'd0);
        chk("midrst_ready", 32'(lsu_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        wr("post_rst1", 1'b0, 5'd0, 32'd0);
        chk("post_rst_ready", 32'(lsu_ready), 32'd1);
        tick();
        wr("post_rst2", 1'b0, 5'd0, 32'd0);
        chk("post_rst_mask", pending_mask, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
